// File: rtl/dfi_init_seq.sv
// dfi_init_seq: controller-side LPDDR4 power-up sequencer on the DFI bus.
// Drives reset_n, cke and the init_start/init_complete training handshake.
module dfi_init_seq #(
    parameter int NPHASES        = 8,
    parameter int CNT_W          = 16,
    parameter int T_RESET_CYC    = 200,
    parameter int T_CKE_CYC      = 2000,
    parameter int T_INIT_TIMEOUT = 65535
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    output logic [NPHASES-1:0] dfi_reset_n_o,
    output logic [NPHASES-1:0] dfi_cke_o,
    output logic [NPHASES-1:0] dfi_cs_n_o,
    output logic               dfi_init_start_o,
    input  logic               dfi_init_complete_i,
    output logic               init_done_o,
    output logic               init_error_o,
    output logic [2:0]         state_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RST_HOLD  = 3'd1;
    localparam logic [2:0] S_CKE_WAIT  = 3'd2;
    localparam logic [2:0] S_INIT_ACK  = 3'd3;
    localparam logic [2:0] S_INIT_WAIT = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET_CYC);
    localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE_CYC);
    localparam logic [CNT_W-1:0] LD_TO    = CNT_W'(T_INIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_n_q, reset_n_d;
    logic             cke_q, cke_d;
    logic             init_start_q, init_start_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             cnt_term;

    assign cnt_term = (cnt_q == CNT_ONE);

    // Next-state and counter: a loaded value N spends exactly N cycles in the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d = S_RST_HOLD;
                    cnt_d   = LD_RESET;
                end
            end
            S_RST_HOLD: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_term) begin
                    state_d = S_CKE_WAIT;
                    cnt_d   = LD_CKE;
                end
            end
            S_CKE_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_term) begin
                    state_d = S_INIT_ACK;
                    cnt_d   = LD_TO;
                end
            end
            S_INIT_ACK: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_term) begin
                    state_d = S_ERROR;
                end else if (!dfi_init_complete_i) begin
                    state_d = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (dfi_init_complete_i) begin
                    state_d = S_DONE;
                end else if (cnt_term) begin
                    state_d = S_ERROR;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        reset_n_d    = !(state_d == S_IDLE || state_d == S_RST_HOLD);
        cke_d        = state_d inside {S_INIT_ACK, S_INIT_WAIT, S_DONE, S_ERROR};
        init_start_d = state_d inside {S_INIT_ACK, S_INIT_WAIT};
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERROR);
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            reset_n_q    <= 1'b0;
            cke_q        <= 1'b0;
            init_start_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reset_n_q    <= reset_n_d;
            cke_q        <= cke_d;
            init_start_q <= init_start_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign dfi_reset_n_o    = {NPHASES{reset_n_q}};
    assign dfi_cke_o        = {NPHASES{cke_q}};
    assign dfi_cs_n_o       = '1;
    assign dfi_init_start_o = init_start_q;
    assign init_done_o      = done_q;
    assign init_error_o     = error_q;
    assign state_o          = state_q;

endmodule
